sample_mem_arbiter: RTL and testbench
=====================================

// Module: sample_mem_arbiter
// PURPOSE
//  Shares the encoding slot's single sample-memory port between two requesters:
//  R0 the frame loader (streams incoming samples into the per-channel buffer) and
//  R1 the host/debug interface (reads and writes the sample memory).
//  Sits between both requesters and the slot's i_sample_mem_* / o_sample_mem_dat pins.
//  It grants bursts round-robin, routes read data back to the owner and flags completed frames.
// PARAMETERS
//  CHANNELS   128  buffer depth (one word per channel)
//  AW         7    address width = clogb2(CHANNELS-1)
//  DW         16   data width of the sample memory
//  MAX_BURST  16   max beats per grant before forced re-arbitration (>=1)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  infer_busy  in   1   inference in progress; host (R1) write beats are held off
//  rX_req      in   1   X in {0,1}: beat request, held with we/adr/wdat/last until accepted
//  rX_we       in   1   1 = write beat, 0 = read beat
//  rX_adr      in   AW  word address
//  rX_wdat     in   DW  write data
//  rX_last     in   1   final beat of the burst
//  rX_gnt      out  1   beat accepted this cycle (req & gnt)
//  rX_rvalid   out  1   read data valid, one cycle after an accepted read beat
//  rX_rdat     out  DW  read data (0 when not rvalid)
//  mem_rd_en   out  1   to i_sample_mem_rd_en
//  mem_wr_en   out  1   to i_sample_mem_wr_en
//  mem_adr     out  AW  to i_sample_mem_adr
//  mem_wdat    out  DW  to i_sample_mem_dat
//  mem_rdat    in   DW  from o_sample_mem_dat, 1-cycle read latency
//  frame_done  out  1   1-cycle pulse: R0 wrote address CHANNELS-1
//  adr_err     out  1   1-cycle pulse: accepted beat had adr >= CHANNELS
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, beat counter 0. last_owner=R1, so R0 wins the first tie.
//  - FSM IDLE / OWN0 / OWN1.
//    - IDLE: one requester -> own it; both -> the one != last_owner; none -> stay.
//    - The transition is registered: gnt asserts from the cycle after entering OWNx.
//  - OWNx:
//    - rX_gnt = rX_req & (state==OWNx), combinational.
//    - For R1, gnt is additionally masked when r1_we & infer_busy. Reads are never masked.
//    - Each accepted beat drives mem_* in the same cycle.
//    - Write: mem_wr_en=1. Read: mem_rd_en=1.
//  - Release from OWNx happens on any of:
//    - an accepted beat with last=1;
//    - the MAX_BURST-th accepted beat;
//    - rX_req low for one cycle.
//    On release, last_owner<=x and the counter clears.
//    The next state is OWN(other) if the other req is high, else IDLE. No idle bubble.
//  - A held-off R1 write under infer_busy keeps ownership only while R0 is idle.
//    If r0_req is high, R1 is released after that cycle.
//  - Read return: registered tag {valid,owner}; next cycle rX_rvalid=1 and rX_rdat=mem_rdat.
//    Back-to-back reads give one rvalid per cycle, in order.
//  - adr >= CHANNELS:
//    - the beat is accepted but mem_rd_en/mem_wr_en stay 0;
//    - adr_err pulses;
//    - a read returns rvalid with rdat=0.
//  - frame_done is registered: it pulses the cycle after an accepted R0 write to CHANNELS-1.
//  - All mem_* outputs are 0 when no beat is accepted.
//  - Reset mid-burst: aborts at once and drops any pending rvalid.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/OWN0/OWN1), requester IDs, clogb2 function.
//  - Single module, no sub-modules. The beat counter width is clogb2(MAX_BURST).
// TESTING
//  1. R0 only, 128 writes adr 0..127 with last on every 16th beat.
//     -> 8 grants; frame_done once, 1 cycle after adr 127; mem_wr_en 128 cycles.
//  2. R0 and R1 raise req the same cycle after reset -> R0 owns first.
//     After R0's last beat R1 owns with no bubble, then R0 again.
//  3. R1 reads adr 5 then 6 back-to-back, memory holds 0xA5A5/0x5A5A.
//     -> r1_rvalid on 2 consecutive cycles with those data; r0_rvalid stays 0.
//  4. infer_busy=1, R1 write adr 3 -> r1_gnt=0, no mem_wr_en.
//     Drop infer_busy -> accepted next cycle.
//     An R1 read during infer_busy is accepted.
//  5. R1 burst of 20 beats with no last -> released after 16 when R0 requests.
//     R0 is served, R1 then resumes the remaining 4.
//  6. R0 write adr 200 -> adr_err pulse, no mem_wr_en.
//     Assert rst mid-burst -> all outputs 0 that cycle; after release, next grant goes to R0.

Source files
------------

// File: rtl/sample_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sample_mem_arbiter_pkg
//  Purpose : Shared types for the sample-memory arbiter: FSM state encoding,
//            requester identifiers and the clogb2 width helper.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package sample_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_t;

  // Number of bits needed to represent 'value' (minimum 1).
  function automatic int clogb2(input int value);
    int v;
    int w;
    v = value;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : sample_mem_arbiter
//  Purpose : Round-robin burst arbiter sharing one sample-memory port between
//            R0 (frame loader) and R1 (host/debug). Routes 1-cycle-latency
//            read data back to the owner, flags completed frames and
//            out-of-range addresses.
//  Ports   : clk, rst            clock, asynchronous active-high reset
//            infer_busy          holds off R1 write beats
//            rX_req/we/adr/wdat/last   beat request from requester X
//            rX_gnt              beat accepted this cycle
//            rX_rvalid/rdat      read return, one cycle after the read beat
//            mem_rd_en/wr_en/adr/wdat  memory command, valid only on a beat
//            mem_rdat            memory read data (1-cycle latency)
//            frame_done          pulse after R0 writes address CHANNELS-1
//            adr_err             pulse on an accepted beat with adr >= CHANNELS
//  Rev     : 1.0  initial release
// ============================================================================
module sample_mem_arbiter
  import sample_mem_arbiter_pkg::*;
#(
  parameter int CHANNELS  = 128,
  parameter int AW        = 7,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          infer_busy,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_wdat,
  input  logic          r0_last,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdat,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_wdat,
  input  logic          r1_last,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdat,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          frame_done,
  output logic          adr_err
);

  localparam int            CW        = clogb2(MAX_BURST);
  localparam logic [CW-1:0] BURST_END = CW'(MAX_BURST - 1);
  // One extra bit so the limit itself is representable when CHANNELS == 2**AW.
  localparam logic [AW:0]   ADR_LIMIT = (AW + 1)'(CHANNELS);
  localparam logic [AW-1:0] LAST_ADR  = AW'(CHANNELS - 1);

  arb_state_t    state, state_nxt;
  req_id_t       last_owner, last_owner_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;

  logic          rd_vld;
  req_id_t       rd_own;
  logic          rd_zero;

  logic          own0, own1;
  logic          beat_acc;
  logic          r1_held;
  logic          sel_req, sel_we, sel_last, oth_req;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdat;
  logic          adr_bad;
  logic          burst_release;
  req_id_t       cur_id;

  assign own0 = (state == ST_OWN0);
  assign own1 = (state == ST_OWN1);

  // A host write while inference runs is stalled, never a host read.
  assign r1_held = own1 & r1_req & r1_we & infer_busy;
  assign r0_gnt  = own0 & r0_req;
  assign r1_gnt  = own1 & r1_req & ~(r1_we & infer_busy);
  assign beat_acc = r0_gnt | r1_gnt;

  // Owner-side view of the beat; only meaningful in an OWN state.
  assign cur_id   = own1 ? REQ_R1 : REQ_R0;
  assign sel_req  = own1 ? r1_req  : r0_req;
  assign sel_we   = own1 ? r1_we   : r0_we;
  assign sel_last = own1 ? r1_last : r0_last;
  assign sel_adr  = own1 ? r1_adr  : r0_adr;
  assign sel_wdat = own1 ? r1_wdat : r0_wdat;
  assign oth_req  = own1 ? r0_req  : r1_req;

  assign adr_bad = ({1'b0, sel_adr} >= ADR_LIMIT);

  // Out-of-range beats are accepted but never reach the memory.
  assign mem_wr_en = beat_acc &  sel_we & ~adr_bad;
  assign mem_rd_en = beat_acc & ~sel_we & ~adr_bad;
  assign mem_adr   = beat_acc ? sel_adr : '0;
  assign mem_wdat  = (beat_acc & sel_we) ? sel_wdat : '0;
  assign adr_err   = beat_acc & adr_bad;

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    burst_release  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (r0_req && (!r1_req || last_owner == REQ_R1)) begin
          state_nxt = ST_OWN0;
        end else if (r1_req) begin
          state_nxt = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (beat_acc) beat_cnt_nxt = beat_cnt + 1'b1;
        // A stalled host write only keeps the port while the loader is quiet.
        burst_release = !sel_req
                      || (beat_acc && (sel_last || beat_cnt == BURST_END))
                      || (r1_held && r0_req);
        if (burst_release) begin
          last_owner_nxt = cur_id;
          beat_cnt_nxt   = '0;
          if (oth_req) state_nxt = own1 ? ST_OWN0 : ST_OWN1;
          else         state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= REQ_R1;
      beat_cnt   <= '0;
      rd_vld     <= 1'b0;
      rd_own     <= REQ_R0;
      rd_zero    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      rd_vld     <= beat_acc & ~sel_we;
      rd_own     <= cur_id;
      rd_zero    <= adr_bad;
      frame_done <= r0_gnt & r0_we & (r0_adr == LAST_ADR);
    end
  end

  assign r0_rvalid = rd_vld & (rd_own == REQ_R0);
  assign r1_rvalid = rd_vld & (rd_own == REQ_R1);
  assign r0_rdat   = (r0_rvalid & ~rd_zero) ? mem_rdat : '0;
  assign r1_rdat   = (r1_rvalid & ~rd_zero) ? mem_rdat : '0;

endmodule
`default_nettype wire

// File: tb/tb_sample_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sample_mem_arbiter
//  Purpose : Self-checking bench for sample_mem_arbiter. A behavioural memory
//            answers the mem_* port; a read scoreboard holds expected
//            {owner, data, cycle} entries pushed when read beats are accepted.
//            AW is widened to 8 so out-of-range addresses can be driven.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sample_mem_arbiter;

  localparam int CHANNELS = 128;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic infer_busy = 1'b0;
  logic [1:0] req = '0, we = '0, last = '0;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat [2];
  logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdat, r1_rdat;
  logic mem_rd_en, mem_wr_en, frame_done, adr_err;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdat, mem_rdat;
  logic [DW-1:0] mem [256];

  int cyc = 0;
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, fd_cnt = 0, fd_cyc = -1, ae_cnt = 0, g0_rise = 0;

  typedef struct {
    int          who;
    logic [15:0] data;
    int          cyc;
  } sb_t;
  sb_t sb[$];
  logic [15:0] shadow [128];

  sample_mem_arbiter #(.CHANNELS(CHANNELS), .AW(AW), .DW(DW), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .infer_busy(infer_busy),
    .r0_req(req[0]), .r0_we(we[0]), .r0_adr(adr[0]), .r0_wdat(wdat[0]), .r0_last(last[0]),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdat(r0_rdat),
    .r1_req(req[1]), .r1_we(we[1]), .r1_adr(adr[1]), .r1_wdat(wdat[1]), .r1_last(last[1]),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdat(r1_rdat),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_adr(mem_adr),
    .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
    .frame_done(frame_done), .adr_err(adr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_adr] <= mem_wdat;
    if (mem_rd_en) mem_rdat <= mem[mem_adr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_rd_en, mem_wr_en, frame_done,
            adr_err, mem_adr, mem_wdat, r0_rdat, r1_rdat};
  endfunction

  function automatic logic gnt_of(input int who);
    return (who == 0) ? r0_gnt : r1_gnt;
  endfunction

  // Drive one beat (called just after a rising edge); returns the cycle it was accepted.
  task automatic send_beat(input int who, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic l, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    req[who] = 1'b1; we[who] = w; adr[who] = a; wdat[who] = d; last[who] = l;
    while (acc_cyc < 0 && n < 200) begin
      @(negedge clk);
      if (gnt_of(who)) begin
        acc_cyc = cyc;
        if (!w) sb.push_back('{who, (a < AW'(CHANNELS)) ? shadow[a[6:0]] : 16'h0, cyc + 1});
        else if (a < AW'(CHANNELS)) shadow[a[6:0]] = d;
      end
      @(posedge clk); #1;
      n++;
    end
    if (acc_cyc < 0) check_eq($sformatf("beat_timeout_r%0d", who), 64'd0, 64'd1);
  endtask

  task automatic monitor_loop();
    sb_t e;
    logic p0;
    p0 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wr_en) wr_cnt++;
        if (mem_rd_en) rd_cnt++;
        if (adr_err) ae_cnt++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (r0_gnt && !p0) g0_rise++;
        if (r0_rvalid && r1_rvalid) check_eq("rvalid_both", 64'd1, 64'd0);
        if (!r0_rvalid && r0_rdat != 0) check_eq("r0_rdat_idle", 64'(r0_rdat), 64'd0);
        if (!r1_rvalid && r1_rdat != 0) check_eq("r1_rdat_idle", 64'(r1_rdat), 64'd0);
        if (r0_rvalid || r1_rvalid) begin
          if (sb.size() == 0) begin
            check_eq("rvalid_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check_eq("rv_owner", {63'd0, r1_rvalid}, 64'(e.who));
            check_eq("rv_data", 64'(r1_rvalid ? r1_rdat : r0_rdat), 64'(e.data));
            check_eq("rv_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
      p0 = r0_gnt;
    end
  endtask

  task automatic do_reset();
    req = '0; we = '0; last = '0; infer_busy = 1'b0;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int c0a, c0b, c0c, c1a, c1b, ca, cb, acc127, n, snap_wr, snap_rd, snap_ae, snap_g, snap_fd;
    int c1 [20];
    for (int i = 0; i < 2; i++) begin adr[i] = '0; wdat[i] = '0; end
    for (int i = 0; i < 128; i++) shadow[i] = '0;
    fork
      monitor_loop();
      begin
        #2ms;
        check_eq("global_timeout", 64'd0, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs_in_rst", all_outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outs_idle", all_outs(), 64'd0);
    @(posedge clk); #1;

    // 1: R0 streams a full frame in 16-beat bursts
    snap_wr = wr_cnt; snap_g = g0_rise; snap_fd = fd_cnt; acc127 = -1;
    for (int i = 0; i < 128; i++) begin
      send_beat(0, 1'b1, AW'(i), 16'h1000 + 16'(i), (i % 16) == 15, ca);
      if (i == 127) acc127 = ca;
    end
    req[0] = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("t1_grants", 64'(g0_rise - snap_g), 64'd8);
    check_eq("t1_wr_cycles", 64'(wr_cnt - snap_wr), 64'd128);
    check_eq("t1_frame_done_cnt", 64'(fd_cnt - snap_fd), 64'd1);
    check_eq("t1_frame_done_cyc", 64'(fd_cyc), 64'(acc127 + 1));

    // 2: simultaneous request after reset, R0 first, handovers without bubble
    do_reset();
    fork
      begin
        send_beat(0, 1'b1, 8'd10, 16'h0A0A, 1'b0, c0a);
        send_beat(0, 1'b1, 8'd11, 16'h0B0B, 1'b1, c0b);
        send_beat(0, 1'b1, 8'd12, 16'h0C0C, 1'b1, c0c);
        req[0] = 1'b0;
      end
      begin
        send_beat(1, 1'b1, 8'd20, 16'h2020, 1'b0, c1a);
        send_beat(1, 1'b1, 8'd21, 16'h2121, 1'b1, c1b);
        req[1] = 1'b0;
      end
    join
    check_eq("t2_r0_first", {63'd0, c0a < c1a}, 64'd1);
    check_eq("t2_r1_no_bubble", 64'(c1a), 64'(c0b + 1));
    check_eq("t2_r0_again", 64'(c0c), 64'(c1b + 1));

    // 3: R1 writes then reads back-to-back
    send_beat(1, 1'b1, 8'd5, 16'hA5A5, 1'b0, ca);
    send_beat(1, 1'b1, 8'd6, 16'h5A5A, 1'b1, ca);
    snap_rd = rd_cnt;
    send_beat(1, 1'b0, 8'd5, 16'h0, 1'b0, ca);
    send_beat(1, 1'b0, 8'd6, 16'h0, 1'b1, cb);
    req[1] = 1'b0;
    check_eq("t3_back_to_back", 64'(cb), 64'(ca + 1));
    repeat (2) @(posedge clk); #1;
    check_eq("t3_rd_cycles", 64'(rd_cnt - snap_rd), 64'd2);

    // 4: host write held off by inference, host read never held off
    infer_busy = 1'b1;
    snap_wr = wr_cnt;
    req[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'd3; wdat[1] = 16'h3333; last[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_held_gnt%0d", i), {63'd0, r1_gnt}, 64'd0);
      @(posedge clk); #1;
    end
    check_eq("t4_held_no_wr", 64'(wr_cnt - snap_wr), 64'd0);
    infer_busy = 1'b0;
    n = cyc;
    send_beat(1, 1'b1, 8'd3, 16'h3333, 1'b1, ca);
    check_eq("t4_release_accept", 64'(ca), 64'(n));
    infer_busy = 1'b1;
    send_beat(1, 1'b0, 8'd3, 16'h0, 1'b1, ca);
    req[1] = 1'b0; infer_busy = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 5: 20-beat R1 burst is cut at 16 when R0 asks, then resumes
    fork
      begin
        for (int i = 0; i < 20; i++)
          send_beat(1, 1'b1, 8'd40 + 8'(i), 16'h5000 + 16'(i), 1'b0, c1[i]);
        req[1] = 1'b0;
      end
      begin
        repeat (4) @(posedge clk); #1;
        send_beat(0, 1'b1, 8'd90, 16'h9090, 1'b1, c0a);
        req[0] = 1'b0;
      end
    join
    n = 0;
    for (int i = 0; i < 20; i++) if (c1[i] < c0a) n++;
    check_eq("t5_beats_before_r0", 64'(n), 64'd16);
    check_eq("t5_r0_no_bubble", 64'(c0a), 64'(c1[15] + 1));
    check_eq("t5_r1_resume", 64'(c1[16]), 64'(c0a + 1));
    repeat (2) @(posedge clk); #1;

    // 6: out-of-range address, then reset mid-burst
    snap_wr = wr_cnt; snap_rd = rd_cnt; snap_ae = ae_cnt;
    send_beat(0, 1'b1, 8'd200, 16'hDEAD, 1'b1, ca);
    req[0] = 1'b0;
    check_eq("t6_adr_err_wr", 64'(ae_cnt - snap_ae), 64'd1);
    check_eq("t6_no_wr", 64'(wr_cnt - snap_wr), 64'd0);
    send_beat(1, 1'b0, 8'd200, 16'h0, 1'b1, ca);
    req[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    check_eq("t6_adr_err_rd", 64'(ae_cnt - snap_ae), 64'd2);
    check_eq("t6_no_rd", 64'(rd_cnt - snap_rd), 64'd0);

    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'd7; last[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!r1_gnt) begin @(posedge clk); #1; end
    end while (!r1_gnt && n < 50);
    check_eq("t6_burst_started", {63'd0, r1_gnt}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_mid_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    req = '0;
    rst = 1'b0;
    fork
      send_beat(0, 1'b1, 8'd61, 16'h6161, 1'b1, ca);
      send_beat(1, 1'b1, 8'd62, 16'h6262, 1'b1, cb);
    join
    req = '0;
    check_eq("t6_r0_after_rst", {63'd0, ca < cb}, 64'd1);

    repeat (3) @(posedge clk); #1;
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
